// File: rtl/fpu_ctrl_pkg.sv
// Shared types and constants for the FPU issue controller: FSM states,
// opcode widths, modifier bit positions and the one-hot opcode check.
package fpu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_e;

  localparam logic [2:0] FRM_DYN     = 3'b111;
  localparam int         FLAG_W      = 5;
  localparam int         SFPU_OP_W   = 24;
  localparam int         VFPU_OP_W   = 28;
  localparam int         SFPU_MOD_LO = 22;
  localparam int         VFPU_MOD_LO = 26;

  // True when exactly one of the low nbits opcode bits is set; the modifier
  // bits above nbits may be combined freely with the base operation.
  function automatic logic base_onehot(input logic [VFPU_OP_W-1:0] op,
                                       input int nbits);
    int cnt;
    cnt = 0;
    for (int i = 0; i < VFPU_OP_W; i++) begin
      if ((i < nbits) && op[i]) cnt++;
    end
    return (cnt == 1);
  endfunction

endpackage

// File: rtl/fpu_rr_arbiter.sv
// Two-way round-robin arbiter between the scalar and vector request ports.
// The pointer moves to the port that was not granted whenever a grant is taken.
module fpu_rr_arbiter
  import fpu_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_s,
  input  logic req_v,
  input  logic en,
  input  logic accept,
  output logic gnt_s,
  output logic gnt_v
);

  logic ptr_v;

  always_comb begin
    gnt_s = 1'b0;
    gnt_v = 1'b0;
    if (en) begin
      if (ptr_v) begin
        gnt_v = req_v;
        gnt_s = req_s & ~req_v;
      end else begin
        gnt_s = req_s;
        gnt_v = req_v & ~req_s;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_v <= 1'b0;
    end else if (accept) begin
      ptr_v <= gnt_s;
    end
  end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Issue controller for a single-cycle FPU shared by a scalar and a vector
// requester: arbitrates, validates, issues one operation and returns its response.
module fpu_issue_ctrl
  import fpu_ctrl_pkg::*;
#(
  parameter int STD = 15,
  parameter int TW  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_req_valid,
  output logic                  s_req_ready,
  input  logic [SFPU_OP_W-1:0]  s_req_op,
  input  logic [2:0]            s_req_frm,
  input  logic [TW-1:0]         s_req_tag,
  input  logic [STD:0]          s_req_a,
  input  logic [STD:0]          s_req_b,
  input  logic [STD:0]          s_req_c,
  input  logic [31:0]           s_req_int,
  input  logic                  v_req_valid,
  output logic                  v_req_ready,
  input  logic [VFPU_OP_W-1:0]  v_req_op,
  input  logic [2:0]            v_req_frm,
  input  logic [TW-1:0]         v_req_tag,
  input  logic [STD:0]          v_req_a,
  input  logic [STD:0]          v_req_b,
  input  logic [STD:0]          v_req_c,
  input  logic [31:0]           v_req_int,
  output logic [STD:0]          fpu_a,
  output logic [STD:0]          fpu_b,
  output logic [STD:0]          fpu_c,
  output logic [31:0]           fpu_int,
  output logic [2:0]            fpu_frm,
  output logic [SFPU_OP_W-1:0]  fpu_sfpu_op,
  output logic [VFPU_OP_W-1:0]  fpu_vfpu_op,
  input  logic [STD:0]          fpu_resultant,
  input  logic [31:0]           fpu_result_rd,
  input  logic [FLAG_W-1:0]     fpu_flags,
  input  logic                  fpu_exc,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_src,
  output logic [TW-1:0]         rsp_tag,
  output logic [STD:0]          rsp_fp,
  output logic [31:0]           rsp_rd,
  output logic [FLAG_W-1:0]     rsp_flags,
  output logic                  rsp_exc,
  output logic                  rsp_illegal,
  input  logic [2:0]            csr_frm,
  input  logic                  fflags_clr,
  output logic [FLAG_W-1:0]     fflags
);

  state_e                 state, state_nxt;
  logic                   arb_en;
  logic                   gnt_s, gnt_v, accept;

  logic [VFPU_OP_W-1:0]   in_op;
  logic [2:0]             in_frm, eff_frm;
  logic [TW-1:0]          in_tag;
  logic [STD:0]           in_a, in_b, in_c;
  logic [31:0]            in_int;
  logic                   in_illegal;
  int                     mod_lo;

  logic                   req_src;
  logic [VFPU_OP_W-1:0]   req_op;
  logic [2:0]             req_frm;
  logic [TW-1:0]          req_tag;
  logic [STD:0]           req_a, req_b, req_c;
  logic [31:0]            req_int;

  // Readies are held low in the reset cycle as well as outside IDLE.
  assign arb_en = (state == ST_IDLE) && !rst;
  assign accept = gnt_s | gnt_v;

  fpu_rr_arbiter u_arb (
    .clk    (clk),
    .rst    (rst),
    .req_s  (s_req_valid),
    .req_v  (v_req_valid),
    .en     (arb_en),
    .accept (accept),
    .gnt_s  (gnt_s),
    .gnt_v  (gnt_v)
  );

  assign s_req_ready = gnt_s;
  assign v_req_ready = gnt_v;

  always_comb begin
    in_op  = {{(VFPU_OP_W-SFPU_OP_W){1'b0}}, s_req_op};
    in_frm = s_req_frm;
    in_tag = s_req_tag;
    in_a   = s_req_a;
    in_b   = s_req_b;
    in_c   = s_req_c;
    in_int = s_req_int;
    mod_lo = SFPU_MOD_LO;
    if (gnt_v) begin
      in_op  = v_req_op;
      in_frm = v_req_frm;
      in_tag = v_req_tag;
      in_a   = v_req_a;
      in_b   = v_req_b;
      in_c   = v_req_c;
      in_int = v_req_int;
      mod_lo = VFPU_MOD_LO;
    end
    eff_frm    = (in_frm == FRM_DYN) ? csr_frm : in_frm;
    in_illegal = (eff_frm == 3'd5) || (eff_frm == 3'd6) || !base_onehot(in_op, mod_lo);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Illegal requests bypass the FPU and go straight to the response state.
  always_comb begin
    state_nxt   = state;
    rsp_valid   = 1'b0;
    fpu_sfpu_op = '0;
    fpu_vfpu_op = '0;
    case (state)
      ST_IDLE: begin
        if (accept) state_nxt = in_illegal ? ST_RESP : ST_ISSUE;
      end
      ST_ISSUE: begin
        state_nxt = ST_WAIT;
        if (req_src) fpu_vfpu_op = req_op;
        else         fpu_sfpu_op = req_op[SFPU_OP_W-1:0];
      end
      ST_WAIT: begin
        state_nxt = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign fpu_a   = req_a;
  assign fpu_b   = req_b;
  assign fpu_c   = req_c;
  assign fpu_int = req_int;
  assign fpu_frm = req_frm;
  assign rsp_src = req_src;
  assign rsp_tag = req_tag;

  // ---- accept: request capture; WAIT: FPU result capture ----
  always_ff @(posedge clk) begin
    if (rst) begin
      req_src     <= 1'b0;
      req_op      <= '0;
      req_frm     <= '0;
      req_tag     <= '0;
      req_a       <= '0;
      req_b       <= '0;
      req_c       <= '0;
      req_int     <= '0;
      rsp_fp      <= '0;
      rsp_rd      <= '0;
      rsp_flags   <= '0;
      rsp_exc     <= 1'b0;
      rsp_illegal <= 1'b0;
    end else if (state == ST_IDLE && accept) begin
      req_src     <= gnt_v;
      req_op      <= in_op;
      req_frm     <= eff_frm;
      req_tag     <= in_tag;
      req_a       <= in_a;
      req_b       <= in_b;
      req_c       <= in_c;
      req_int     <= in_int;
      rsp_fp      <= '0;
      rsp_rd      <= '0;
      rsp_flags   <= '0;
      rsp_exc     <= 1'b0;
      rsp_illegal <= in_illegal;
    end else if (state == ST_WAIT) begin
      rsp_fp      <= fpu_resultant;
      rsp_rd      <= fpu_result_rd;
      rsp_flags   <= fpu_flags;
      rsp_exc     <= fpu_exc;
    end
  end

  // A clear coinciding with a capture still lets the new flags accrue.
  always_ff @(posedge clk) begin
    if (rst) begin
      fflags <= '0;
    end else if (state == ST_WAIT) begin
      fflags <= (fflags_clr ? '0 : fflags) | fpu_flags;
    end else if (fflags_clr) begin
      fflags <= '0;
    end
  end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl: a registered FPU stub returns bench-chosen
// results one cycle after each opcode pulse; each task checks one behaviour.
module tb_fpu_issue_ctrl;

  localparam int STD = 15;
  localparam int TW  = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           s_req_valid = 1'b0;
  logic           s_req_ready;
  logic [23:0]    s_req_op = '0;
  logic [2:0]     s_req_frm = '0;
  logic [TW-1:0]  s_req_tag = '0;
  logic [STD:0]   s_req_a = '0, s_req_b = '0, s_req_c = '0;
  logic [31:0]    s_req_int = '0;
  logic           v_req_valid = 1'b0;
  logic           v_req_ready;
  logic [27:0]    v_req_op = '0;
  logic [2:0]     v_req_frm = '0;
  logic [TW-1:0]  v_req_tag = '0;
  logic [STD:0]   v_req_a = '0, v_req_b = '0, v_req_c = '0;
  logic [31:0]    v_req_int = '0;
  logic [STD:0]   fpu_a, fpu_b, fpu_c;
  logic [31:0]    fpu_int;
  logic [2:0]     fpu_frm;
  logic [23:0]    fpu_sfpu_op;
  logic [27:0]    fpu_vfpu_op;
  logic [STD:0]   fpu_resultant = '0;
  logic [31:0]    fpu_result_rd = '0;
  logic [4:0]     fpu_flags = '0;
  logic           fpu_exc = 1'b0;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic           rsp_src;
  logic [TW-1:0]  rsp_tag;
  logic [STD:0]   rsp_fp;
  logic [31:0]    rsp_rd;
  logic [4:0]     rsp_flags;
  logic           rsp_exc;
  logic           rsp_illegal;
  logic [2:0]     csr_frm = '0;
  logic           fflags_clr = 1'b0;
  logic [4:0]     fflags;

  logic [STD:0]   stub_fp = '0;
  logic [31:0]    stub_rd = '0;
  logic [4:0]     stub_flags = '0;
  int             pulse_cnt = 0;
  int             checks = 0;
  int             fails = 0;

  fpu_issue_ctrl #(.STD(STD), .TW(TW)) dut (
    .clk(clk), .rst(rst),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_op(s_req_op),
    .s_req_frm(s_req_frm), .s_req_tag(s_req_tag), .s_req_a(s_req_a),
    .s_req_b(s_req_b), .s_req_c(s_req_c), .s_req_int(s_req_int),
    .v_req_valid(v_req_valid), .v_req_ready(v_req_ready), .v_req_op(v_req_op),
    .v_req_frm(v_req_frm), .v_req_tag(v_req_tag), .v_req_a(v_req_a),
    .v_req_b(v_req_b), .v_req_c(v_req_c), .v_req_int(v_req_int),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_c(fpu_c), .fpu_int(fpu_int),
    .fpu_frm(fpu_frm), .fpu_sfpu_op(fpu_sfpu_op), .fpu_vfpu_op(fpu_vfpu_op),
    .fpu_resultant(fpu_resultant), .fpu_result_rd(fpu_result_rd),
    .fpu_flags(fpu_flags), .fpu_exc(fpu_exc),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_src(rsp_src),
    .rsp_tag(rsp_tag), .rsp_fp(rsp_fp), .rsp_rd(rsp_rd), .rsp_flags(rsp_flags),
    .rsp_exc(rsp_exc), .rsp_illegal(rsp_illegal),
    .csr_frm(csr_frm), .fflags_clr(fflags_clr), .fflags(fflags)
  );

  always #5 clk = ~clk;

  // Single-cycle FPU stand-in with registered outputs.
  always @(posedge clk) begin
    if (fpu_sfpu_op != '0 || fpu_vfpu_op != '0) begin
      fpu_resultant <= stub_fp;
      fpu_result_rd <= stub_rd;
      fpu_flags     <= stub_flags;
      pulse_cnt     <= pulse_cnt + 1;
    end else begin
      fpu_flags     <= '0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Legal scalar op with rsp_ready high: accept, then three edges back to IDLE.
  task automatic run_scalar_op();
    s_req_valid = 1'b1;
    step();
    s_req_valid = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_reset();
    rst = 1'b1; s_req_valid = 1'b1; v_req_valid = 1'b1; s_req_op = 24'h1; v_req_op = 28'h1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (s_req_ready !== 1'b0) begin fails++; $display("FAIL reset_s_ready: got %b want 0", s_req_ready); end
    checks++; if (v_req_ready !== 1'b0) begin fails++; $display("FAIL reset_v_ready: got %b want 0", v_req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    checks++; if (fflags !== 5'b0) begin fails++; $display("FAIL reset_fflags: got %b want 00000", fflags); end
    checks++; if (fpu_sfpu_op !== 24'h0 || fpu_vfpu_op !== 28'h0) begin fails++; $display("FAIL reset_opbus: got %h/%h want 0/0", fpu_sfpu_op, fpu_vfpu_op); end
    checks++; if (fpu_a !== 16'h0) begin fails++; $display("FAIL reset_fpu_a: got %h want 0000", fpu_a); end
    checks++; if (rsp_tag !== 4'h0 || rsp_illegal !== 1'b0) begin fails++; $display("FAIL reset_rsp_regs: got tag %h ill %b want 0/0", rsp_tag, rsp_illegal); end
    step();
    rst = 1'b0; s_req_valid = 1'b0; v_req_valid = 1'b0;
    step();
  endtask

  task automatic test_scalar_fadd();
    stub_fp = 16'h4000; stub_flags = 5'b0; rsp_ready = 1'b1; csr_frm = 3'b000;
    s_req_op = 24'h000001; s_req_frm = 3'b000; s_req_tag = 4'd3;
    s_req_a = 16'h3C00; s_req_b = 16'h3C00; s_req_valid = 1'b1;
    @(negedge clk);
    checks++; if (s_req_ready !== 1'b1 || v_req_ready !== 1'b0) begin fails++; $display("FAIL fadd_ready: got %b%b want 10", s_req_ready, v_req_ready); end
    step();
    s_req_valid = 1'b0;
    @(negedge clk);
    checks++; if (fpu_sfpu_op !== 24'h000001 || fpu_vfpu_op !== 28'h0) begin fails++; $display("FAIL fadd_issue_op: got %h/%h want 000001/0", fpu_sfpu_op, fpu_vfpu_op); end
    checks++; if (fpu_a !== 16'h3C00 || fpu_b !== 16'h3C00) begin fails++; $display("FAIL fadd_operands: got %h %h want 3c00 3c00", fpu_a, fpu_b); end
    checks++; if (rsp_valid !== 1'b0 || s_req_ready !== 1'b0) begin fails++; $display("FAIL fadd_issue_ctl: got valid %b ready %b want 0 0", rsp_valid, s_req_ready); end
    @(negedge clk);
    checks++; if (fpu_sfpu_op !== 24'h0 || rsp_valid !== 1'b0) begin fails++; $display("FAIL fadd_wait: got op %h valid %b want 0 0", fpu_sfpu_op, rsp_valid); end
    checks++; if (fpu_a !== 16'h3C00) begin fails++; $display("FAIL fadd_operand_hold: got %h want 3c00", fpu_a); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL fadd_rsp_valid: got %b want 1", rsp_valid); end
    checks++; if (rsp_fp !== 16'h4000) begin fails++; $display("FAIL fadd_rsp_fp: got %h want 4000", rsp_fp); end
    checks++; if (rsp_src !== 1'b0 || rsp_tag !== 4'd3 || rsp_illegal !== 1'b0) begin fails++; $display("FAIL fadd_rsp_id: got src %b tag %0d ill %b want 0 3 0", rsp_src, rsp_tag, rsp_illegal); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL fadd_rsp_done: got %b want 0", rsp_valid); end
    step();
  endtask

  task automatic test_round_robin();
    logic exp_s;
    do_reset();
    rsp_ready = 1'b1; s_req_frm = 3'b000; v_req_frm = 3'b000;
    s_req_op = 24'h1; v_req_op = 28'h1; s_req_tag = 4'd1; v_req_tag = 4'd2;
    s_req_valid = 1'b1; v_req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_s = (i[0] == 1'b0);
      @(negedge clk);
      checks++; if (s_req_ready !== exp_s || v_req_ready !== !exp_s) begin fails++; $display("FAIL rr_grant%0d: got s%b v%b want s%b v%b", i, s_req_ready, v_req_ready, exp_s, !exp_s); end
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        checks++; if ((s_req_ready | v_req_ready) !== 1'b0) begin fails++; $display("FAIL rr_busy_ready%0d_%0d: got s%b v%b want 00", i, k, s_req_ready, v_req_ready); end
      end
      checks++; if (rsp_valid !== 1'b1 || rsp_src !== !exp_s) begin fails++; $display("FAIL rr_rsp_src%0d: got valid %b src %b want 1 %b", i, rsp_valid, rsp_src, !exp_s); end
    end
    step();
    s_req_valid = 1'b0; v_req_valid = 1'b0;
    step();
  endtask

  task automatic test_frm();
    logic [4:0] fl0;
    int pc0;
    rsp_ready = 1'b1; stub_flags = 5'b0;
    csr_frm = 3'b010; s_req_frm = 3'b111; s_req_op = 24'h1; s_req_valid = 1'b1;
    step();
    s_req_valid = 1'b0;
    @(negedge clk);
    checks++; if (fpu_frm !== 3'b010 || fpu_sfpu_op !== 24'h1) begin fails++; $display("FAIL frm_dynamic: got frm %b op %h want 010 000001", fpu_frm, fpu_sfpu_op); end
    @(negedge clk);
    @(negedge clk);
    step();
    fl0 = fflags; pc0 = pulse_cnt; stub_flags = 5'b11111;
    s_req_frm = 3'b101; s_req_tag = 4'd7; s_req_valid = 1'b1;
    step();
    s_req_valid = 1'b0;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1 || rsp_illegal !== 1'b1) begin fails++; $display("FAIL illegal_frm_rsp: got valid %b ill %b want 1 1", rsp_valid, rsp_illegal); end
    checks++; if (rsp_fp !== 16'h0 || rsp_flags !== 5'b0 || rsp_rd !== 32'h0 || rsp_exc !== 1'b0) begin fails++; $display("FAIL illegal_frm_fields: got fp %h fl %b rd %h exc %b want zeros", rsp_fp, rsp_flags, rsp_rd, rsp_exc); end
    checks++; if (rsp_tag !== 4'd7 || fpu_sfpu_op !== 24'h0) begin fails++; $display("FAIL illegal_frm_tag_op: got tag %0d op %h want 7 0", rsp_tag, fpu_sfpu_op); end
    step();
    @(negedge clk);
    checks++; if (pulse_cnt !== pc0 || fflags !== fl0) begin fails++; $display("FAIL illegal_frm_side: got pulses %0d fflags %b want %0d %b", pulse_cnt, fflags, pc0, fl0); end
    step();
    s_req_frm = 3'b000; s_req_op = 24'h000003; s_req_valid = 1'b1;
    step();
    s_req_valid = 1'b0;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1 || rsp_illegal !== 1'b1) begin fails++; $display("FAIL illegal_twohot: got valid %b ill %b want 1 1", rsp_valid, rsp_illegal); end
    step();
    csr_frm = 3'b110; s_req_frm = 3'b111; s_req_op = 24'h000001; s_req_valid = 1'b1;
    step();
    s_req_valid = 1'b0;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1 || rsp_illegal !== 1'b1) begin fails++; $display("FAIL illegal_dyn_frm: got valid %b ill %b want 1 1", rsp_valid, rsp_illegal); end
    step();
    stub_flags = 5'b0; csr_frm = 3'b000; s_req_frm = 3'b000; s_req_op = 24'h400001; s_req_valid = 1'b1;
    step();
    s_req_valid = 1'b0;
    @(negedge clk);
    checks++; if (fpu_sfpu_op !== 24'h400001 || rsp_valid !== 1'b0) begin fails++; $display("FAIL modifier_legal: got op %h valid %b want 400001 0", fpu_sfpu_op, rsp_valid); end
    @(negedge clk);
    @(negedge clk);
    checks++; if (rsp_illegal !== 1'b0) begin fails++; $display("FAIL modifier_rsp: got ill %b want 0", rsp_illegal); end
    step();
  endtask

  task automatic test_back_to_back();
    rsp_ready = 1'b0; stub_fp = 16'h1234; stub_flags = 5'b0;
    s_req_op = 24'h1; s_req_frm = 3'b000; s_req_tag = 4'd5; s_req_valid = 1'b1;
    step();
    s_req_valid = 1'b0;
    v_req_valid = 1'b1; v_req_op = 28'h2; v_req_frm = 3'b000; v_req_tag = 4'd9;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL bp_rsp_valid: got %b want 1", rsp_valid); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b1 || rsp_fp !== 16'h1234 || rsp_tag !== 4'd5 || (s_req_ready | v_req_ready) !== 1'b0) begin
        fails++; $display("FAIL bp_hold%0d: got valid %b fp %h tag %0d rdy %b%b want 1 1234 5 00", k, rsp_valid, rsp_fp, rsp_tag, s_req_ready, v_req_ready);
      end
    end
    step();
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if (v_req_ready !== 1'b0) begin fails++; $display("FAIL bp_pre_handshake_ready: got %b want 0", v_req_ready); end
    @(negedge clk);
    checks++; if (v_req_ready !== 1'b1 || rsp_valid !== 1'b0) begin fails++; $display("FAIL bp_next_accept: got ready %b valid %b want 1 0", v_req_ready, rsp_valid); end
    step();
    v_req_valid = 1'b0;
    @(negedge clk);
    checks++; if (fpu_vfpu_op !== 28'h2 || fpu_sfpu_op !== 24'h0) begin fails++; $display("FAIL bp_vec_issue: got v %h s %h want 0000002 0", fpu_vfpu_op, fpu_sfpu_op); end
    @(negedge clk);
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1 || rsp_src !== 1'b1 || rsp_tag !== 4'd9) begin fails++; $display("FAIL bp_vec_rsp: got valid %b src %b tag %0d want 1 1 9", rsp_valid, rsp_src, rsp_tag); end
    step();
  endtask

  task automatic test_fflags();
    do_reset();
    rsp_ready = 1'b1; s_req_op = 24'h1; s_req_frm = 3'b000;
    stub_flags = 5'b00001;
    run_scalar_op();
    stub_flags = 5'b10000;
    run_scalar_op();
    @(negedge clk);
    checks++; if (fflags !== 5'b10001) begin fails++; $display("FAIL fflags_accrue: got %b want 10001", fflags); end
    step();
    stub_flags = 5'b00100; s_req_valid = 1'b1;
    step();
    s_req_valid = 1'b0;
    step();
    fflags_clr = 1'b1;
    step();
    fflags_clr = 1'b0;
    @(negedge clk);
    checks++; if (fflags !== 5'b00100 || rsp_flags !== 5'b00100) begin fails++; $display("FAIL fflags_clr_capture: got %b rsp %b want 00100 00100", fflags, rsp_flags); end
    step();
    fflags_clr = 1'b1;
    step();
    fflags_clr = 1'b0;
    @(negedge clk);
    checks++; if (fflags !== 5'b00000) begin fails++; $display("FAIL fflags_clr_idle: got %b want 00000", fflags); end
    step();
  endtask

  task automatic test_reset_mid();
    logic seen;
    rsp_ready = 1'b1; stub_fp = 16'hBEEF; stub_flags = 5'b01000;
    s_req_op = 24'h1; s_req_a = 16'h5555; s_req_valid = 1'b1;
    step();
    s_req_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0 || fpu_sfpu_op !== 24'h0 || fpu_vfpu_op !== 28'h0) begin fails++; $display("FAIL midrst_idle: got valid %b op %h/%h want 0 0/0", rsp_valid, fpu_sfpu_op, fpu_vfpu_op); end
    checks++; if (fflags !== 5'b0 || fpu_a !== 16'h0) begin fails++; $display("FAIL midrst_regs: got fflags %b fpu_a %h want 00000 0000", fflags, fpu_a); end
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin fails++; $display("FAIL midrst_no_rsp: got %b want 0", seen); end
    step();
  endtask

  initial begin
    test_reset();
    test_scalar_fadd();
    test_round_robin();
    test_frm();
    test_back_to_back();
    test_fflags();
    test_reset_mid();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/fpu_issue_ctrl.md
FPU_ISSUE_CTRL -- requirements
Module: fpu_issue_ctrl

Interface
REQ-001 Parameters: STD=15, FP operand MSB index; TW=4, request tag width.
REQ-002 clk  in  1  sole clock; every register updates on its rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 s_req_valid/s_req_ready  in/out  1/1  scalar-port handshake.
REQ-005 s_req_op/s_req_frm/s_req_tag  in  24/3/TW  scalar sfpu one-hot opcode, rounding mode, tag.
REQ-006 s_req_a/s_req_b/s_req_c/s_req_int  in  STD+1 x3/32  scalar operands.
REQ-007 v_req_valid/v_req_ready  in/out  1/1  vector-port handshake.
REQ-008 v_req_op/v_req_frm/v_req_tag/v_req_a/b/c/int  in  28/3/TW/STD+1 x3/32  vector-port fields; vfpu one-hot opcode.
REQ-009 fpu_a/b/c/int, fpu_frm, fpu_sfpu_op, fpu_vfpu_op  out  STD+1 x3/32, 3, 24, 28  drive the single-cycle FPU.
REQ-010 fpu_resultant/fpu_result_rd/fpu_flags/fpu_exc  in  STD+1/32/5/1  FPU registered outputs.
REQ-011 rsp_valid/rsp_ready  out/in  1/1  response handshake.
REQ-012 rsp_src/rsp_tag/rsp_fp/rsp_rd/rsp_flags/rsp_exc/rsp_illegal  out  1/TW/STD+1/32/5/1/1  response; src 0=scalar, 1=vector.
REQ-013 csr_frm/fflags_clr  in  3/1  dynamic rounding mode; fflags clear.
REQ-014 fflags  out  5  sticky accrued flags {NV,DZ,OF,UF,NX}.

Function
REQ-015 FSM states: IDLE, ISSUE, WAIT, RESP; one operation outstanding at a time.
REQ-016 IDLE: the arbiter grants one valid requester, ready is asserted to that requester only, and on handshake the fields are registered and the FSM moves to ISSUE.
REQ-017 Arbitration: 2-way round-robin; the pointer flips to the other port after each grant; after reset the pointer favours scalar; a single valid requester is always granted.
REQ-018 Both readies SHALL be 0 in ISSUE, WAIT and RESP.
REQ-019 Effective frm: equals csr_frm, sampled at accept, when req_frm=3'b111; otherwise equals req_frm.
REQ-020 Illegal request: effective frm is 5 or 6, or the opcode bits excluding the modifiers (sfpu[23:22], vfpu[27:26]) are not exactly one-hot; the FSM goes IDLE->RESP directly with rsp_illegal=1, fp/rd/flags/exc=0, no FPU pulse, and fflags unchanged.
REQ-021 ISSUE: the registered operands, frm and opcode are driven for exactly one cycle, on the originating port's opcode bus only; the other opcode bus is 0.
REQ-022 Outside ISSUE, fpu_sfpu_op and fpu_vfpu_op SHALL be 0; the operand buses hold their last values.
REQ-023 WAIT: fpu_resultant, fpu_result_rd, fpu_flags and fpu_exc are captured into the response registers, and the FSM moves to RESP.
REQ-024 RESP: rsp_valid=1; all rsp fields stay stable until rsp_ready; on handshake the FSM returns to IDLE; a new accept is possible the next cycle.
REQ-025 Latency: a request accepted at edge N gives rsp_valid=1 from cycle N+3, with rsp_ready held high.
REQ-026 Latency: the minimum issue interval is 4 cycles.
REQ-027 fflags update at the WAIT capture: fflags_next = (fflags_clr ? 0 : fflags) | fpu_flags.
REQ-028 fflags_clr in any other cycle: fflags is cleared.
REQ-029 rsp_tag and rsp_src echo the accepted request.

Reset
REQ-030 When rst is 1 at an edge: FSM=IDLE, arbiter pointer=scalar, fflags=0, all rsp registers=0, rsp_valid=0, FPU opcode buses=0, operand buses=0.
REQ-031 Reset mid-operation (ISSUE/WAIT/RESP) discards the operation; no response is ever delivered for it.
REQ-032 Readies SHALL be 0 during the reset cycle.

Structure
REQ-033 Package fpu_ctrl_pkg holds: the state enum, FRM_DYN=3'b111, FLAG_W=5, the modifier bit indices and the widths 24/28.
REQ-034 Sub-module fpu_rr_arbiter contains the 2-way round-robin grant and pointer; the FSM and datapath registers remain in fpu_issue_ctrl.

Verification
REQ-035 Scalar fadd, op=24'h000001, a=b=16'h3C00, frm=0, tag=3, accepted at N -> fpu_sfpu_op=000001 only in cycle N+1; rsp_valid at N+3 with rsp_fp=16'h4000, src=0, tag=3.
REQ-036 Both ports valid continuously for four operations after reset -> grant order S,V,S,V; no ready asserted outside IDLE.
REQ-037 frm=3'b111 with csr_frm=3'b010 -> fpu_frm=010; frm=3'b101 -> rsp_illegal=1, no opcode pulse, fflags unchanged.
REQ-038 rsp_ready held low 5 cycles -> rsp fields stable and both readies 0; the next accept occurs the cycle after the response handshake.
REQ-039 Flag returns 5'b00001 then 5'b10000 -> fflags=5'b10001; then fflags_clr coincident with a capture of 5'b00100 -> fflags=5'b00100.
REQ-040 rst asserted while in WAIT -> next cycle IDLE, rsp_valid=0, opcode buses 0; that operation never produces a response.
